comp_config_loader: RTL and testbench

- Avalon-MM slave register file that stages filter patterns (port, IP, MAC, URL) written by the host.
- On a host commit, it sequences the staged values into the four match comparators in a fixed order, then pulses update_done to the packet controller.
- The controller leaves its comparator-register-load state on that pulse.
- It is the single configuration path for the comparator bank; comparators never see partially written patterns.

---
 rtl/comp_config_loader.sv | 232 +++++++++++++++++++++++
 tb/tb_comp_config_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comp_config_loader.sv
// Host-visible staging registers for the packet filter patterns, and the sequencer
// that copies them into the comparator bank one comparator at a time after a commit.
module comp_config_loader #(
  parameter int URL_WORDS = 8,
  parameter int IDX_W     = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       avs_address,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  output logic             avs_waitrequest,
  output logic [15:0]      port_val,
  output logic [31:0]      ip_val,
  output logic [47:0]      mac_val,
  output logic [31:0]      url_word,
  output logic [IDX_W-1:0] url_idx,
  output logic [5:0]       url_len,
  output logic             port_ld,
  output logic             ip_ld,
  output logic             mac_ld,
  output logic             url_ld,
  output logic             update_done,
  output logic             busy
);

  localparam logic [5:0]       MAX_LEN  = 6'(4 * URL_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(URL_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_PORT, S_LOAD_IP, S_LOAD_MAC, S_LOAD_URL, S_DONE
  } state_t;

  state_t r_state, w_state_next;

  // Staging registers (host side)
  logic [15:0] r_port;
  logic [31:0] r_ip;
  logic [47:0] r_mac;
  logic [5:0]  r_len;
  logic [31:0] r_url_mem [URL_WORDS];

  // Registered outputs
  logic [15:0]      r_port_val, w_port_val_next;
  logic [31:0]      r_ip_val, w_ip_val_next;
  logic [47:0]      r_mac_val, w_mac_val_next;
  logic [31:0]      r_url_word, w_url_word_next;
  logic [IDX_W-1:0] r_url_idx, w_url_idx_next;
  logic [5:0]       r_url_len, w_url_len_next;
  logic             r_port_ld, w_port_ld_next;
  logic             r_ip_ld, w_ip_ld_next;
  logic             r_mac_ld, w_mac_ld_next;
  logic             r_url_ld, w_url_ld_next;
  logic             r_update_done, w_update_done_next;
  logic             r_busy, w_busy_next;
  logic [31:0]      r_readdata, w_readdata_next;

  logic       w_wr_acc, w_rd_acc, w_commit;
  logic [5:0] w_len_sat;
  logic [31:0] w_url_rd;
  logic        w_url_hit;

  // The bus stalls for the whole sequence, so staging is frozen while loading.
  assign w_wr_acc  = avs_write && !r_busy;
  assign w_rd_acc  = avs_read && !r_busy;
  assign w_commit  = w_wr_acc && (avs_address == 4'd13) && avs_writedata[0];
  assign w_len_sat = (avs_writedata[5:0] > MAX_LEN) ? MAX_LEN : avs_writedata[5:0];

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_port <= '0;
      r_ip   <= '0;
      r_mac  <= '0;
      r_len  <= '0;
    end else if (w_wr_acc) begin
      case (avs_address)
        4'd0:    r_port        <= avs_writedata[15:0];
        4'd1:    r_ip          <= avs_writedata;
        4'd2:    r_mac[31:0]   <= avs_writedata;
        4'd3:    r_mac[47:32]  <= avs_writedata[15:0];
        4'd12:   r_len         <= w_len_sat;
        default: ;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < URL_WORDS; gi++) begin : g_url
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
          r_url_mem[gi] <= '0;
        else if (w_wr_acc && ({1'b0, avs_address} == 5'(4 + gi)))
          r_url_mem[gi] <= avs_writedata;
      end
    end
  endgenerate

  always_comb begin
    w_url_rd  = '0;
    w_url_hit = 1'b0;
    for (int i = 0; i < URL_WORDS; i++) begin
      if ({1'b0, avs_address} == 5'(4 + i)) begin
        w_url_rd  = r_url_mem[i];
        w_url_hit = 1'b1;
      end
    end
  end

  // Read mux samples staging before any same-cycle write lands.
  always_comb begin
    w_readdata_next = r_readdata;
    if (w_rd_acc) begin
      case (avs_address)
        4'd0:    w_readdata_next = {16'b0, r_port};
        4'd1:    w_readdata_next = r_ip;
        4'd2:    w_readdata_next = r_mac[31:0];
        4'd3:    w_readdata_next = {16'b0, r_mac[47:32]};
        4'd12:   w_readdata_next = {26'b0, r_len};
        4'd13:   w_readdata_next = {31'b0, r_busy};
        default: w_readdata_next = w_url_hit ? w_url_rd : 32'd0;
      endcase
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_port_val_next    = r_port_val;
    w_ip_val_next      = r_ip_val;
    w_mac_val_next     = r_mac_val;
    w_url_word_next    = r_url_word;
    w_url_idx_next     = r_url_idx;
    w_url_len_next     = r_url_len;
    w_port_ld_next     = 1'b0;
    w_ip_ld_next       = 1'b0;
    w_mac_ld_next      = 1'b0;
    w_url_ld_next      = 1'b0;
    w_update_done_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_commit) begin
          w_state_next    = S_LOAD_PORT;
          w_port_ld_next  = 1'b1;
          w_port_val_next = r_port;
        end
      end
      S_LOAD_PORT: begin
        w_state_next  = S_LOAD_IP;
        w_ip_ld_next  = 1'b1;
        w_ip_val_next = r_ip;
      end
      S_LOAD_IP: begin
        w_state_next   = S_LOAD_MAC;
        w_mac_ld_next  = 1'b1;
        w_mac_val_next = r_mac;
      end
      S_LOAD_MAC: begin
        w_state_next    = S_LOAD_URL;
        w_url_ld_next   = 1'b1;
        w_url_idx_next  = '0;
        w_url_word_next = r_url_mem[0];
      end
      S_LOAD_URL: begin
        // url_idx doubles as the word counter; every word is loaded regardless of url_len.
        if (r_url_idx == LAST_IDX) begin
          w_state_next       = S_DONE;
          w_update_done_next = 1'b1;
          w_url_len_next     = r_len;
        end else begin
          w_url_ld_next   = 1'b1;
          w_url_idx_next  = r_url_idx + 1'b1;
          w_url_word_next = r_url_mem[r_url_idx + 1'b1];
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state       <= S_IDLE;
      r_port_val    <= '0;
      r_ip_val      <= '0;
      r_mac_val     <= '0;
      r_url_word    <= '0;
      r_url_idx     <= '0;
      r_url_len     <= '0;
      r_port_ld     <= 1'b0;
      r_ip_ld       <= 1'b0;
      r_mac_ld      <= 1'b0;
      r_url_ld      <= 1'b0;
      r_update_done <= 1'b0;
      r_busy        <= 1'b0;
      r_readdata    <= '0;
    end else begin
      r_state       <= w_state_next;
      r_port_val    <= w_port_val_next;
      r_ip_val      <= w_ip_val_next;
      r_mac_val     <= w_mac_val_next;
      r_url_word    <= w_url_word_next;
      r_url_idx     <= w_url_idx_next;
      r_url_len     <= w_url_len_next;
      r_port_ld     <= w_port_ld_next;
      r_ip_ld       <= w_ip_ld_next;
      r_mac_ld      <= w_mac_ld_next;
      r_url_ld      <= w_url_ld_next;
      r_update_done <= w_update_done_next;
      r_busy        <= w_busy_next;
      r_readdata    <= w_readdata_next;
    end
  end

  assign avs_readdata    = r_readdata;
  assign avs_waitrequest = r_busy;
  assign busy            = r_busy;
  assign port_val        = r_port_val;
  assign ip_val          = r_ip_val;
  assign mac_val         = r_mac_val;
  assign url_word        = r_url_word;
  assign url_idx         = r_url_idx;
  assign url_len         = r_url_len;
  assign port_ld         = r_port_ld;
  assign ip_ld           = r_ip_ld;
  assign mac_ld          = r_mac_ld;
  assign url_ld          = r_url_ld;
  assign update_done     = r_update_done;

endmodule

// File: tb/tb_comp_config_loader.sv
// Directed plus randomized bench for comp_config_loader; expected values come from a
// register-map model and a per-cycle timeline of the load sequence after each commit.
module tb_comp_config_loader;

  localparam int URL_WORDS = 8;
  localparam int IDX_W     = 3;
  localparam int MAX_LEN   = 4 * URL_WORDS;

  logic             clk, n_rst;
  logic [3:0]       avs_address;
  logic             avs_write, avs_read;
  logic [31:0]      avs_writedata, avs_readdata;
  logic             avs_waitrequest;
  logic [15:0]      port_val;
  logic [31:0]      ip_val, mac_lo_unused, url_word;
  logic [47:0]      mac_val;
  logic [IDX_W-1:0] url_idx;
  logic [5:0]       url_len;
  logic             port_ld, ip_ld, mac_ld, url_ld, update_done, busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: staged register contents and the url_len last delivered to the comparators.
  logic [15:0] mdl_port;
  logic [31:0] mdl_ip;
  logic [47:0] mdl_mac;
  logic [31:0] mdl_url [URL_WORDS];
  logic [5:0]  mdl_len;
  logic [5:0]  mdl_loaded_len;

  comp_config_loader #(.URL_WORDS(URL_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .n_rst(n_rst),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_read(avs_read), .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .port_val(port_val), .ip_val(ip_val), .mac_val(mac_val),
    .url_word(url_word), .url_idx(url_idx), .url_len(url_len),
    .port_ld(port_ld), .ip_ld(ip_ld), .mac_ld(mac_ld), .url_ld(url_ld),
    .update_done(update_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mdl_port = '0; mdl_ip = '0; mdl_mac = '0; mdl_len = '0; mdl_loaded_len = '0;
    for (int i = 0; i < URL_WORDS; i++) mdl_url[i] = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [3:0] a);
    int ai;
    ai = int'(a);
    if (ai == 0) return {16'b0, mdl_port};
    if (ai == 1) return mdl_ip;
    if (ai == 2) return mdl_mac[31:0];
    if (ai == 3) return {16'b0, mdl_mac[47:32]};
    if (ai >= 4 && ai < 4 + URL_WORDS) return mdl_url[ai - 4];
    if (ai == 12) return {26'b0, mdl_len};
    return 32'd0;  // CTRL reads busy, which is always 0 once the read is accepted
  endfunction

  task automatic model_write(input logic [3:0] a, input logic [31:0] d);
    int ai;
    ai = int'(a);
    if (ai == 0) mdl_port = d[15:0];
    else if (ai == 1) mdl_ip = d;
    else if (ai == 2) mdl_mac[31:0] = d;
    else if (ai == 3) mdl_mac[47:32] = d[15:0];
    else if (ai >= 4 && ai < 4 + URL_WORDS) mdl_url[ai - 4] = d;
    else if (ai == 12) mdl_len = (int'(d[5:0]) > MAX_LEN) ? 6'(MAX_LEN) : d[5:0];
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (avs_waitrequest && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 64'(avs_waitrequest), 64'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    wait_ready("wr_ready");
    tick();
    avs_write = 1'b0;
    model_write(a, d);
    $display("write addr=%0d data=%08h", a, d);
  endtask

  task automatic rd_chk(input logic [3:0] a, input string tag);
    avs_address = a; avs_read = 1'b1;
    wait_ready("rd_ready");
    tick();
    avs_read = 1'b0;
    $display("read  addr=%0d data=%08h", a, avs_readdata);
    chk(tag, 64'(avs_readdata), 64'(exp_read(a)));
  endtask

  // k = cycles since the accepted commit edge; the sequence occupies k = 1 .. URL_WORDS+4.
  task automatic check_cycle(input int k);
    int done_k;
    done_k = URL_WORDS + 4;
    chk("busy",        64'(busy),            64'(k >= 1 && k <= done_k));
    chk("waitrequest", 64'(avs_waitrequest), 64'(k >= 1 && k <= done_k));
    chk("port_ld",     64'(port_ld),         64'(k == 1));
    chk("ip_ld",       64'(ip_ld),           64'(k == 2));
    chk("mac_ld",      64'(mac_ld),          64'(k == 3));
    chk("url_ld",      64'(url_ld),          64'(k >= 4 && k < done_k));
    chk("update_done", 64'(update_done),     64'(k == done_k));
    if (k >= 1) chk("port_val", 64'(port_val), 64'(mdl_port));
    if (k >= 2) chk("ip_val",   64'(ip_val),   64'(mdl_ip));
    if (k >= 3) chk("mac_val",  64'(mac_val),  64'(mdl_mac));
    if (k >= 4 && k < done_k) begin
      chk("url_idx",  64'(url_idx),  64'(k - 4));
      chk("url_word", 64'(url_word), 64'(mdl_url[k - 4]));
    end
    if (k == done_k) mdl_loaded_len = mdl_len;
    chk("url_len", 64'(url_len), 64'(mdl_loaded_len));
  endtask

  task automatic commit_and_check();
    wr(4'd13, 32'd1);
    for (int k = 1; k <= URL_WORDS + 5; k++) begin
      check_cycle(k);
      if (k < URL_WORDS + 5) tick();
    end
    $display("commit port=%04h ip=%08h mac=%012h len=%0d", mdl_port, mdl_ip, mdl_mac, mdl_loaded_len);
  endtask

  initial begin
    logic [31:0] rv;
    logic [3:0]  ra;
    n_rst = 1'b0; avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    model_reset();
    #12;
    chk("rst_busy",     64'(busy),         64'd0);
    chk("rst_readdata", 64'(avs_readdata), 64'd0);
    chk("rst_mac_val",  64'(mac_val),      64'd0);
    tick();
    n_rst = 1'b1;
    tick();

    // Directed: port/ip/mac
    wr(4'd0, 32'h0000_0050);
    wr(4'd1, 32'hC0A8_0001);
    wr(4'd2, 32'hDDEE_FF00);
    wr(4'd3, 32'hAABB_CC11);
    chk("mac_model", mdl_mac, 64'h0000_CC11_DDEE_FF00);
    commit_and_check();

    // Directed: URL words and length
    for (int i = 0; i < URL_WORDS; i++) wr(4'(4 + i), {8{4'(i + 1)}});
    wr(4'd12, 32'd20);
    commit_and_check();

    // url_len saturation, CTRL no-op, unmapped reads
    wr(4'd12, 32'd63);
    rd_chk(4'd12, "len_sat");
    chk("len_sat_value", 64'(avs_readdata), 64'd32);
    wr(4'd13, 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("noop_busy", 64'(busy), 64'd0);
      chk("noop_ld", 64'({port_ld, ip_ld, mac_ld, url_ld, update_done}), 64'd0);
      tick();
    end
    rd_chk(4'd15, "unmapped15");
    rd_chk(4'd14, "unmapped14");

    // Simultaneous write and read: readdata carries the pre-write value
    avs_address = 4'd0; avs_writedata = 32'h0000_1234; avs_write = 1'b1; avs_read = 1'b1;
    wait_ready("wr_rd_ready");
    tick();
    avs_write = 1'b0; avs_read = 1'b0;
    chk("wr_rd_old", 64'(avs_readdata), 64'(exp_read(4'd0)));
    model_write(4'd0, 32'h0000_1234);
    rd_chk(4'd0, "wr_rd_new");

    // Host write issued mid-load stalls until the sequence ends; load uses the old port
    wr(4'd13, 32'd1);
    for (int k = 1; k <= URL_WORDS + 4; k++) begin
      check_cycle(k);
      if (k == 5) begin
        avs_address = 4'd0; avs_writedata = 32'h0000_BEEF; avs_write = 1'b1;
      end
      tick();
    end
    chk("stall_released", 64'(avs_waitrequest), 64'd0);
    tick();
    avs_write = 1'b0;
    model_write(4'd0, 32'h0000_BEEF);
    rd_chk(4'd0, "stalled_write");

    // CTRL read issued during a load returns 0 once it is accepted
    wr(4'd13, 32'd1);
    rd_chk(4'd13, "ctrl_rd_load");
    mdl_loaded_len = mdl_len;

    // Randomized rounds
    for (int r = 0; r < 4; r++) begin
      for (int a = 0; a < 4 + URL_WORDS; a++) wr(4'(a), $urandom);
      wr(4'd12, 32'($urandom_range(0, 63)));
      for (int j = 0; j < 5; j++) begin
        ra = 4'($urandom_range(0, 15));
        if (ra == 4'd13) ra = 4'd14;
        rd_chk(ra, "rand_read");
      end
      commit_and_check();
    end

    // Reset in the middle of a load
    wr(4'd13, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      check_cycle(k);
      if (k < 6) tick();
    end
    #2 n_rst = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_strobes", 64'({port_ld, ip_ld, mac_ld, url_ld, update_done}), 64'd0);
    chk("arst_vals", 64'({port_val, ip_val, url_word}), 64'd0);
    chk("arst_mac", 64'(mac_val), 64'd0);
    chk("arst_url", 64'({url_idx, url_len}), 64'd0);
    chk("arst_readdata", 64'(avs_readdata), 64'd0);
    tick();
    n_rst = 1'b1;
    model_reset();
    for (int k = 0; k < URL_WORDS + 6; k++) begin
      tick();
      chk("post_rst_idle", 64'({busy, update_done}), 64'd0);
    end
    for (int a = 0; a < 16; a++) begin
      rv = 32'(a);
      rd_chk(rv[3:0], "post_rst_read");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  assign mac_lo_unused = mac_val[31:0];

endmodule
